// File: rtl/mul4s_rr_sched.sv
// Round-robin scheduler sharing one 4x4 signed multiplier among NREQ requesters.
// The operand register (S1) feeds the core, and the product register (S2) drives a tagged result port.

module mul4s_core (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  // Sign-extend both operands to 8 bits; the 8-bit product covers the full range.
  assign p_o = $signed({{4{a_i[3]}}, a_i}) * $signed({{4{b_i[3]}}, b_i});
endmodule

module mul4s_rr_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0][3:0] req_a_i,
  input  logic [NREQ-1:0][3:0] req_b_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [7:0]           res_prod_o,
  output logic [IDW-1:0]       res_id_o,
  output logic                 busy_o
);

  typedef struct packed {
    logic [3:0]     a;
    logic [3:0]     b;
    logic [IDW-1:0] id;
  } op_t;

  logic           s1_vld_q, s1_vld_d;
  op_t            s1_q, s1_d;
  logic           res_vld_q, res_vld_d;
  logic [7:0]     prod_q, prod_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           s2_adv, accept, found, hs;
  logic [IDW-1:0] gnt;
  int             idx;
  logic [7:0]     core_p;

  assign s2_adv = !res_vld_q | res_ready_i;
  assign accept = !rst_i & (!s1_vld_q | s2_adv);
  assign hs     = found & accept;

  // First valid requester scanning from ptr upward, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt] = 1'b1;
  end

  mul4s_core u_core (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (core_p)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    res_vld_d = res_vld_q;
    prod_d    = prod_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    if (s2_adv) begin
      res_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        prod_d = core_p;
        id_d   = s1_q.id;
      end
      s1_vld_d = 1'b0;
    end
    if (hs) begin
      s1_vld_d = 1'b1;
      s1_d     = '{a: req_a_i[gnt], b: req_b_i[gnt], id: gnt};
      ptr_d    = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      res_vld_q <= 1'b0;
      prod_q    <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      res_vld_q <= res_vld_d;
      prod_q    <= prod_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign res_valid_o = res_vld_q;
  assign res_prod_o  = prod_q;
  assign res_id_o    = id_q;
  assign busy_o      = s1_vld_q | res_vld_q;

endmodule
